// File: rtl/mul_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mul_rr_arbiter
//   Shares one external combinational multiplier between two requesters.
//   A three-state sequencer (IDLE -> CALC -> RESP) drives the multiplier
//   operands, captures the product one cycle later and presents it on the
//   shared response bus until the granted requester takes it. When both
//   requesters are valid, the one that was not served last wins.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/ready      request handshake per requester
//   req{0,1}_a, req{0,1}_b    operands per requester (WIDTH bits)
//   rsp{0,1}_valid/ready      response handshake per requester
//   rsp_s                     registered product, shared by both responses
//   mul_a, mul_b, mul_s       registered operands to / product from multiplier
//   busy                      sequencer is not in IDLE
//   done0_cnt, done1_cnt      delivered responses per requester (wrapping)
// ---------------------------------------------------------------------------
module mul_rr_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNTW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [2*WIDTH-1:0] rsp_s,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_s,
   output logic               busy,
   output logic [CNTW-1:0]    done0_cnt,
   output logic [CNTW-1:0]    done1_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_r;
   logic   gnt_r;          // requester owning the transaction in flight
   logic   last_grant_r;   // requester served by the last completed response
   logic   any_valid_s;
   logic   win_s;          // 0 = requester 0 wins, 1 = requester 1 wins
   logic   rsp_fire_s;

   // Round-robin winner selection from the current request valids
   always_comb begin
      any_valid_s = req0_valid | req1_valid;
      win_s       = 1'b0;
      if (req0_valid && req1_valid) begin
         // contention: the requester not served last goes first
         win_s = ~last_grant_r;
      end else if (req1_valid) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Handshake outputs; readys only in IDLE and forced low while reset is held
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      if (!rst && (state_r == IDLE) && any_valid_s) begin
         req0_ready = ~win_s;
         req1_ready = win_s;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
      if (!rst && (state_r == RESP)) begin
         rsp0_valid = ~gnt_r;
         rsp1_valid = gnt_r;
      end else begin
         rsp0_valid = 1'b0;
         rsp1_valid = 1'b0;
      end
      rsp_fire_s = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
      busy       = (state_r != IDLE);
   end

   // Sequencer: operand latch, product capture, response delivery, counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         gnt_r        <= 1'b0;
         last_grant_r <= 1'b1;
         mul_a        <= '0;
         mul_b        <= '0;
         rsp_s        <= '0;
         done0_cnt    <= '0;
         done1_cnt    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_valid_s) begin
                  mul_a   <= win_s ? req1_a : req0_a;
                  mul_b   <= win_s ? req1_b : req0_b;
                  gnt_r   <= win_s;
                  state_r <= CALC;
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               rsp_s   <= mul_s;
               state_r <= RESP;
            end
            RESP: begin
               if (rsp_fire_s) begin
                  if (gnt_r) begin
                     done1_cnt <= done1_cnt + CNTW'(1);
                  end else begin
                     done0_cnt <= done0_cnt + CNTW'(1);
                  end
                  last_grant_r <= gnt_r;
                  state_r      <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_rr_arbiter
//   Directed bench for mul_rr_arbiter. The external multiplier is modelled
//   as a plain combinational product. Inputs change on the falling edge,
//   outputs are sampled on the falling edge (plus #1 for combinational readys).
// ---------------------------------------------------------------------------
module tb_mul_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [7:0] rsp_s;
   logic [3:0] mul_a, mul_b;
   logic [7:0] mul_s;
   logic       busy;
   logic [7:0] done0_cnt, done1_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign mul_s = {4'b0000, mul_a} * {4'b0000, mul_b};

   mul_rr_arbiter #(.WIDTH(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_s(rsp_s), .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
      .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
      req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      total++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
      end
      total++;
      if ({rsp_s, mul_a, mul_b} !== 16'h0000) begin
         bad++;
         $display("FAIL reset_data: got %h want 0000", {rsp_s, mul_a, mul_b});
      end
      total++;
      if ({done0_cnt, done1_cnt} !== 16'h0000) begin
         bad++;
         $display("FAIL reset_cnt: got %h want 0000", {done0_cnt, done1_cnt});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, req0_ready, req1_ready} !== 3'b000) begin
         bad++;
         $display("FAIL reset_idle: got %b want 000", {busy, req0_ready, req1_ready});
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++;
         $display("FAIL single_rdy: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      total++;
      if ({busy, req0_ready, mul_a, mul_b} !== {1'b1, 1'b0, 4'd3, 4'd5}) begin
         bad++;
         $display("FAIL single_calc: got %h want %h", {busy, req0_ready, mul_a, mul_b}, {1'b1, 1'b0, 4'd3, 4'd5});
      end
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, rsp_s} !== {1'b1, 1'b0, 8'd15}) begin
         bad++;
         $display("FAIL single_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp_s}, {1'b1, 1'b0, 8'd15});
      end
      @(negedge clk);
      total++;
      if ({busy, done0_cnt} !== {1'b0, 8'd1}) begin
         bad++;
         $display("FAIL single_done: got %h want %h", {busy, done0_cnt}, {1'b0, 8'd1});
      end
   endtask

   task automatic test_contention();
      apply_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd7;  req0_b = 4'd9;
      req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++;
         $display("FAIL cont_first_rdy: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      total++;
      if (req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL cont_stall_calc: got %b want 0", req1_ready);
      end
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, rsp_s} !== {1'b1, 1'b0, 8'd63}) begin
         bad++;
         $display("FAIL cont_rsp0: got %h want %h", {rsp0_valid, rsp1_valid, rsp_s}, {1'b1, 1'b0, 8'd63});
      end
      // requester 0 re-raises while its own response is still pending
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd6;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         bad++;
         $display("FAIL cont_pending_rdy: got %b want 00", {req0_ready, req1_ready});
      end
      @(negedge clk);
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++;
         $display("FAIL cont_second_rdy: got %b want 01", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      total++;
      if (req0_ready !== 1'b0) begin
         bad++;
         $display("FAIL cont_stall_calc2: got %b want 0", req0_ready);
      end
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, rsp_s} !== {1'b0, 1'b1, 8'd225}) begin
         bad++;
         $display("FAIL cont_rsp1: got %h want %h", {rsp0_valid, rsp1_valid, rsp_s}, {1'b0, 1'b1, 8'd225});
      end
      @(negedge clk);
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++;
         $display("FAIL cont_third_rdy: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp_s} !== {1'b1, 8'd12}) begin
         bad++;
         $display("FAIL cont_rsp0b: got %h want %h", {rsp0_valid, rsp_s}, {1'b1, 8'd12});
      end
      @(negedge clk);
      total++;
      if ({done0_cnt, done1_cnt} !== {8'd2, 8'd1}) begin
         bad++;
         $display("FAIL cont_counts: got %h want %h", {done0_cnt, done1_cnt}, {8'd2, 8'd1});
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd5;
      #1;
      total++;
      if (req1_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept: got %b want 1", req1_ready);
      end
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if ({rsp1_valid, rsp0_valid, rsp_s, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, 8'd20, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bp_hold[%0d]: got %h want %h", i,
                     {rsp1_valid, rsp0_valid, rsp_s, req0_ready, req1_ready, busy},
                     {1'b1, 1'b0, 8'd20, 1'b0, 1'b0, 1'b1});
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      rsp1_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, rsp1_valid, done0_cnt, done1_cnt} !== {1'b0, 1'b0, 8'd2, 8'd2}) begin
         bad++;
         $display("FAIL bp_release: got %h want %h", {busy, rsp1_valid, done0_cnt, done1_cnt},
                  {1'b0, 1'b0, 8'd2, 8'd2});
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_a = 4'(a); req0_b = 4'(b);
            exp = 8'(a * b);
            #1;
            total++;
            if (req0_ready !== 1'b1) begin
               bad++;
               $display("FAIL sweep_rdy %0d*%0d: got %b want 1", a, b, req0_ready);
            end
            @(negedge clk);
            req0_valid = 1'b0;
            @(negedge clk);
            total++;
            if ({rsp0_valid, rsp_s} !== {1'b1, exp}) begin
               bad++;
               $display("FAIL sweep_prod %0d*%0d: got %0d want %0d", a, b, rsp_s, exp);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
      @(negedge clk);
      req0_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_calc: got %b want 1", busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, rsp0_valid, rsp1_valid, rsp_s, mul_a, mul_b, done0_cnt, done1_cnt} !== 35'h0) begin
         bad++;
         $display("FAIL midrst_zero: got %h want 0",
                  {busy, rsp0_valid, rsp1_valid, rsp_s, mul_a, mul_b, done0_cnt, done1_cnt});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_norsp[%0d]: got %b want 000", i, {busy, rsp0_valid, rsp1_valid});
         end
      end
      req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
      req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++;
         $display("FAIL midrst_grant: got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp_s} !== {1'b1, 8'd42}) begin
         bad++;
         $display("FAIL midrst_rsp: got %h want %h", {rsp0_valid, rsp_s}, {1'b1, 8'd42});
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (i == 255) begin
            total++;
            if (done1_cnt !== 8'hFF) begin
               bad++;
               $display("FAIL wrap_max: got %0d want 255", done1_cnt);
            end
         end
         req1_valid = 1'b1; req1_a = 4'(i); req1_b = 4'd1;
         #1;
         total++;
         if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL wrap_rdy[%0d]: got %b want 1", i, req1_ready);
         end
         @(negedge clk);
         req1_valid = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      total++;
      if ({done1_cnt, done0_cnt, busy} !== {8'd0, 8'd0, 1'b0}) begin
         bad++;
         $display("FAIL wrap_zero: got %h want 0", {done1_cnt, done0_cnt, busy});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_sweep();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
